clk_div_multi: RTL and testbench

//  Parametrised multi-channel clock divider / tick generator for the system clock domain.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_chan.sv | 80 ++++++++
 rtl/clk_div_multi.sv | 71 +++++++
 tb/tb_clk_div_multi.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Channel-select width; at least one bit so a single-channel build still has a port.
    function automatic int unsigned chw(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, terminal-count detect, shadow config and registered outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CW       = 28,
    parameter int unsigned DEF_DIV  = 500000,
    parameter int unsigned DEF_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          cfg_wr,
    input  logic [CW-1:0] cfg_div,
    input  logic          cfg_mode,
    output logic          pend,
    output logic          tick,
    output logic          clk_out
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] div_act;
    logic          mode_act;
    logic [CW-1:0] sh_div;
    logic          sh_mode;
    logic          tc;

    // Terminal count compared at full counter width.
    assign tc = (cnt == div_act - CW'(1));

    // Counter, apply-at-TC of shadow settings, tick and clk_out generation.
    // A shadow written in the TC cycle is not yet pending, so it waits for the following TC.
    // On apply, clk_out restarts low; the TC tick still fires when the outgoing mode is
    // TOGGLE, and is suppressed when it is PULSE so clk_out and tick never disagree there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            div_act  <= CW'(DEF_DIV);
            mode_act <= 1'(DEF_MODE);
            sh_div   <= CW'(DEF_DIV);
            sh_mode  <= 1'(DEF_MODE);
            pend     <= 1'b0;
            tick     <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            if (!en) begin
                cnt     <= '0;
                tick    <= 1'b0;
                clk_out <= 1'b0;
                if (pend) begin
                    div_act  <= sh_div;
                    mode_act <= sh_mode;
                    pend     <= 1'b0;
                end
            end else if (tc) begin
                cnt <= '0;
                if (pend) begin
                    div_act  <= sh_div;
                    mode_act <= sh_mode;
                    pend     <= 1'b0;
                    clk_out  <= 1'b0;
                    tick     <= (mode_act == MODE_TOGGLE);
                end else begin
                    tick    <= 1'b1;
                    clk_out <= (mode_act == MODE_TOGGLE) ? ~clk_out : 1'b1;
                end
            end else begin
                cnt     <= cnt + CW'(1);
                tick    <= 1'b0;
                clk_out <= (mode_act == MODE_TOGGLE) ? clk_out : 1'b0;
            end

            if (cfg_wr) begin
                sh_div  <= cfg_div;
                sh_mode <= cfg_mode;
                pend    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider / tick generator with a valid/ready config port.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CW       = 28,
    parameter int unsigned DEF_DIV  = 500000,
    parameter int unsigned DEF_MODE = 0,
    localparam int unsigned CHW     = chw(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic           cfg_mode,
    output logic           cfg_err,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick
);

    localparam int unsigned NSEL = 32'(1) << CHW;

    logic [NCH-1:0]  pend;
    logic [NCH-1:0]  cfg_wr;
    logic [NSEL-1:0] pend_pad;
    logic            ch_ok;
    logic            div_ok;
    logic            accept;

    // Request decode and ready mux; out-of-range channels are always ready so they can be dropped.
    always_comb begin
        pend_pad  = NSEL'(pend);
        ch_ok     = (32'(cfg_ch) < NCH);
        div_ok    = (cfg_div != '0);
        cfg_ready = ch_ok ? ~pend_pad[cfg_ch] : 1'b1;
        accept    = cfg_valid & cfg_ready;
    end

    // Flag an accepted request that was dropped as invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept & ~(ch_ok & div_ok);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign cfg_wr[i] = accept & ch_ok & div_ok & (cfg_ch == CHW'(i));

        clk_div_chan #(
            .CW       (CW),
            .DEF_DIV  (DEF_DIV),
            .DEF_MODE (DEF_MODE)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .cfg_wr   (cfg_wr[i]),
            .cfg_div  (cfg_div),
            .cfg_mode (cfg_mode),
            .pend     (pend[i]),
            .tick     (tick[i]),
            .clk_out  (clk_out[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: reference model, directed corner cases, random traffic, vector table.
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int unsigned NCH      = 4;
    localparam int unsigned CW       = 8;
    localparam int unsigned DEF_DIV  = 5;
    localparam int unsigned DEF_MODE = 0;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_mode;
    logic           cfg_err;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    // Three-channel instance: exposes an out-of-range channel number on a 2-bit select.
    logic [2:0]     en3;
    logic           cfg_valid3;
    logic           cfg_ready3;
    logic [1:0]     cfg_ch3;
    logic [CW-1:0]  cfg_div3;
    logic           cfg_mode3;
    logic           cfg_err3;
    logic [2:0]     clk_out3;
    logic [2:0]     tick3;

    int tests = 0;
    int fails = 0;

    clk_div_multi #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF_DIV), .DEF_MODE(DEF_MODE)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
        .clk_out(clk_out), .tick(tick)
    );

    clk_div_multi #(.NCH(3), .CW(CW), .DEF_DIV(DEF_DIV), .DEF_MODE(DEF_MODE)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .cfg_mode(cfg_mode3), .cfg_err(cfg_err3),
        .clk_out(clk_out3), .tick(tick3)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // since = enabled cycles elapsed in the current period; a period ends when it reaches div.
    // nticks = ticks since the last restart; TOGGLE output is its parity.
    int unsigned div_m  [NCH];
    int unsigned sh_div [NCH];
    int unsigned since  [NCH];
    int unsigned nticks [NCH];
    bit          mode_m [NCH];
    bit          sh_mode[NCH];
    bit          pend_m [NCH];
    bit          tick_m [NCH];
    bit          clk_m  [NCH];
    bit          err_m;
    bit          err3_m;
    int unsigned cyc3;

    function automatic bit ready_model();
        if (32'(cfg_ch) >= NCH) return 1'b1;
        return !pend_m[cfg_ch];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                div_m[c] = DEF_DIV; mode_m[c] = 1'(DEF_MODE);
                sh_div[c] = DEF_DIV; sh_mode[c] = 1'(DEF_MODE);
                pend_m[c] = 0; since[c] = 0; nticks[c] = 0; tick_m[c] = 0; clk_m[c] = 0;
            end
            err_m = 0; err3_m = 0; cyc3 = 0;
        end else begin
            bit acc, bad, applied, old_mode;
            int ch;
            ch  = int'(cfg_ch);
            acc = cfg_valid && ready_model();
            bad = (cfg_div == 0) || (ch >= int'(NCH));
            err_m  = acc && bad;
            err3_m = cfg_valid3 && ((int'(cfg_ch3) >= 3) || (cfg_div3 == 0));
            cyc3++;
            for (int c = 0; c < NCH; c++) begin
                applied = 0;
                if (!en[c]) begin
                    since[c] = 0; tick_m[c] = 0; nticks[c] = 0;
                    if (pend_m[c]) begin
                        div_m[c] = sh_div[c]; mode_m[c] = sh_mode[c]; pend_m[c] = 0; applied = 1;
                    end
                end else begin
                    since[c]++;
                    if (since[c] == div_m[c]) begin
                        since[c] = 0;
                        if (pend_m[c]) begin
                            old_mode = mode_m[c];
                            div_m[c] = sh_div[c]; mode_m[c] = sh_mode[c]; pend_m[c] = 0;
                            applied = 1; nticks[c] = 0;
                            tick_m[c] = (old_mode == MODE_TOGGLE);
                        end else begin
                            tick_m[c] = 1; nticks[c]++;
                        end
                    end else begin
                        tick_m[c] = 0;
                    end
                end
                if (!en[c] || applied) clk_m[c] = 0;
                else clk_m[c] = (mode_m[c] == MODE_TOGGLE) ? nticks[c][0] : tick_m[c];
                if (acc && !bad && ch == c) begin
                    sh_div[c] = 32'(cfg_div); sh_mode[c] = cfg_mode; pend_m[c] = 1;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0] et, ec;
        logic [2:0]     et3, ec3;
        for (int c = 0; c < NCH; c++) begin
            et[c] = tick_m[c];
            ec[c] = clk_m[c];
        end
        et3 = (cyc3 > 0 && (cyc3 % 5) == 0) ? 3'b111 : 3'b000;
        ec3 = (((cyc3 / 5) % 2) == 1) ? 3'b111 : 3'b000;
        check("tick",       32'(tick),       32'(et));
        check("clk_out",    32'(clk_out),    32'(ec));
        check("cfg_err",    32'(cfg_err),    32'(err_m));
        check("cfg_ready",  32'(cfg_ready),  32'(ready_model()));
        check("tick3",      32'(tick3),      32'(et3));
        check("clk_out3",   32'(clk_out3),   32'(ec3));
        check("cfg_err3",   32'(cfg_err3),   32'(err3_m));
        check("cfg_ready3", 32'(cfg_ready3), 32'(1));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic do_cfg(input int ch, input int dv, input bit md);
        bit acc;
        acc = 0;
        cfg_valid = 1; cfg_ch = 2'(ch); cfg_div = CW'(dv); cfg_mode = md;
        for (int k = 0; k < 64; k++) begin
            #1;
            acc = cfg_ready;
            step();
            if (acc) break;
        end
        cfg_valid = 0;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL cfg_accept_timeout ch%0d: got not-accepted expected accepted", ch);
        end
    endtask

    // Cycles until tick[ch] is seen high; -1 on timeout.
    task automatic wait_tick(input int ch, input int maxw, output int n);
        n = -1;
        for (int k = 1; k <= maxw; k++) begin
            step();
            if (tick[ch]) begin n = k; break; end
        end
    endtask

    // Length of the next complete high phase of clk_out[ch]; -1 on timeout.
    task automatic high_len(input int ch, output int n);
        int k;
        n = -1;
        k = 0;
        while (clk_out[ch] && k < 64) begin step(); k++; end
        while (!clk_out[ch] && k < 64) begin step(); k++; end
        if (k < 64) begin
            n = 0;
            while (clk_out[ch] && k < 128) begin step(); n++; k++; end
        end
    endtask

    typedef struct {
        int ch;
        int dv;
        bit md;
        int exp_per;
        int exp_high;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        bit hit;

        vecs[0] = '{ch: 0, dv: 1, md: MODE_TOGGLE, exp_per: 1, exp_high: 1};
        vecs[1] = '{ch: 1, dv: 2, md: MODE_TOGGLE, exp_per: 2, exp_high: 2};
        vecs[2] = '{ch: 2, dv: 7, md: MODE_PULSE,  exp_per: 7, exp_high: 1};
        vecs[3] = '{ch: 3, dv: 4, md: MODE_TOGGLE, exp_per: 4, exp_high: 4};
        vecs[4] = '{ch: 0, dv: 3, md: MODE_PULSE,  exp_per: 3, exp_high: 1};
        vecs[5] = '{ch: 1, dv: 9, md: MODE_TOGGLE, exp_per: 9, exp_high: 9};

        rst = 1; en = '1; cfg_valid = 0; cfg_ch = 0; cfg_div = 0; cfg_mode = 0;
        en3 = 3'b111; cfg_valid3 = 0; cfg_ch3 = 0; cfg_div3 = 0; cfg_mode3 = 0;

        // Reset state
        repeat (3) step();
        check("rst_tick",    32'(tick),    32'(0));
        check("rst_clk_out", 32'(clk_out), 32'(0));
        check("rst_cfg_err", 32'(cfg_err), 32'(0));
        rst = 0;

        // First tick lands DEF_DIV cycles after reset release; then period 5
        wait_tick(0, 20, n);
        check("first_tick_latency", 32'(n), 32'(5));
        wait_tick(0, 20, n);
        check("tick_period_default", 32'(n), 32'(5));
        high_len(2, n);
        check("toggle_high_default", 32'(n), 32'(5));

        // Mid-count reconfig of ch1 followed by a second request while pending
        step(); step();
        do_cfg(1, 3, MODE_PULSE);
        cfg_valid = 1; cfg_ch = 2'd1; cfg_div = CW'(4); cfg_mode = MODE_TOGGLE;
        #1;
        check("ready_held_while_pend", 32'(cfg_ready), 32'(0));
        do_cfg(1, 4, MODE_TOGGLE);
        repeat (20) step();

        // Invalid divisor on the main instance, invalid channel on the 3-channel one
        do_cfg(0, 0, MODE_PULSE);
        check("err_div0_pulse", 32'(cfg_err), 32'(1));
        step();
        check("err_div0_clear", 32'(cfg_err), 32'(0));
        cfg_valid3 = 1; cfg_ch3 = 2'd3; cfg_div3 = CW'(2);
        step();
        check("err_ch_pulse", 32'(cfg_err3), 32'(1));
        cfg_valid3 = 0;
        step();
        check("err_ch_clear", 32'(cfg_err3), 32'(0));

        // Accept on ch0 in its TC cycle: one more old period before the new divisor
        hit = 0;
        for (int k = 0; k < 20; k++) begin
            if (since[0] == div_m[0] - 1 && !pend_m[0]) begin hit = 1; break; end
            step();
        end
        check("tc_align_found", 32'(hit), 32'(1));
        do_cfg(0, 2, MODE_TOGGLE);
        check("tc_accept_tick", 32'(tick[0]), 32'(1));
        wait_tick(0, 20, n);
        check("tc_accept_old_period", 32'(n), 32'(5));
        wait_tick(0, 20, n);
        check("tc_accept_new_period", 32'(n), 32'(2));

        // en[2] dropped for 7 cycles
        en[2] = 0;
        step();
        check("en_off_outputs", 32'({tick[2], clk_out[2]}), 32'(0));
        repeat (6) step();
        en[2] = 1;
        repeat (3) step();

        // Reset mid-count with a pending config on ch3
        wait_tick(3, 20, n);
        do_cfg(3, 7, MODE_PULSE);
        cfg_ch = 2'd3;
        #1;
        check("pend_before_rst", 32'(cfg_ready), 32'(0));
        rst = 1;
        step();
        check("rst_mid_ready", 32'(cfg_ready), 32'(1));
        check("rst_mid_tick",  32'(tick),      32'(0));
        step();
        rst = 0;
        wait_tick(3, 20, n);
        check("post_rst_first", 32'(n), 32'(5));
        wait_tick(3, 20, n);
        check("post_rst_period", 32'(n), 32'(5));

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = CW'($urandom_range(0, 9));
            cfg_mode  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            step();
        end
        cfg_valid = 0;
        en = '1;
        repeat (30) step();

        // Vector table: programmed divisor/mode -> tick period and clk_out high time
        foreach (vecs[i]) begin
            do_cfg(vecs[i].ch, vecs[i].dv, vecs[i].md);
            hit = 0;
            for (int k = 0; k < 40; k++) begin
                if (!pend_m[vecs[i].ch]) begin hit = 1; break; end
                step();
            end
            check("vec_apply", 32'(hit), 32'(1));
            wait_tick(vecs[i].ch, 40, n);
            wait_tick(vecs[i].ch, 40, n);
            check($sformatf("vec%0d_period", i), 32'(n), 32'(vecs[i].exp_per));
            high_len(vecs[i].ch, n);
            check($sformatf("vec%0d_high", i), 32'(n), 32'(vecs[i].exp_high));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
